// File: rtl/fcore_rdsched_pkg.sv
// Shared types and constants for the fCore DMA read scheduler.
package fcore_rdsched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQUEST,
    WAIT_RESP,
    EMIT,
    DONE
  } sched_state_t;

  // Beat payload substituted for a channel whose response never arrived.
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/fcore_rdsched_table.sv
// Channel table: register-file address per channel, 0 marks a skipped entry.
// Synchronous write, combinational read, resets to entry i = i+1.
module fcore_rdsched_table
  import fcore_rdsched_pkg::*;
#(
  parameter int unsigned CHANNELS_MAX   = 16,
  parameter int unsigned REG_ADDR_WIDTH = 8,
  localparam int unsigned CW            = $clog2(CHANNELS_MAX)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      we_i,
  input  logic [CW-1:0]             waddr_i,
  input  logic [REG_ADDR_WIDTH-1:0] wdata_i,
  input  logic [CW-1:0]             raddr_i,
  output logic [REG_ADDR_WIDTH-1:0] rdata_o
);

  logic [REG_ADDR_WIDTH-1:0] tbl_q [CHANNELS_MAX];

  // Table storage with identity+1 reset image.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(CHANNELS_MAX); i++) begin
        tbl_q[i] <= REG_ADDR_WIDTH'(i + 1);
      end
    end else if (we_i) begin
      tbl_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/fcore_dma_read_scheduler.sv
// fCore DMA read scheduler: on each trigger walks the channel table, issues one
// read request per non-zero entry and forwards each response as a stream beat
// tagged with its channel index.
// Optional response timeout: define FCORE_RDSCHED_TIMEOUT_EN.
module fcore_dma_read_scheduler
  import fcore_rdsched_pkg::*;
#(
  parameter int unsigned CHANNELS_MAX   = 16,
  parameter int unsigned DATAPATH_WIDTH = 20,
  parameter int unsigned REG_ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned CW            = $clog2(CHANNELS_MAX)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      trigger_i,
  input  logic [CW:0]               n_channels_i,
  input  logic                      cfg_we_i,
  input  logic [CW-1:0]             cfg_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] cfg_data_i,
  output logic                      read_request_valid_o,
  input  logic                      read_request_ready_i,
  output logic [REG_ADDR_WIDTH-1:0] read_request_data_o,
  input  logic                      read_response_valid_i,
  output logic                      read_response_ready_o,
  input  logic [DATAPATH_WIDTH-1:0] read_response_data_i,
  output logic                      data_out_valid_o,
  input  logic                      data_out_ready_i,
  output logic [31:0]               data_out_data_o,
  output logic [CW-1:0]             data_out_dest_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      overrun_o,
  output logic                      timeout_err_o
);

  if (CHANNELS_MAX < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("fcore_dma_read_scheduler: CHANNELS_MAX >= 2 and TIMEOUT_CYCLES >= 1 required");
  end

  sched_state_t              state_q;
  logic [CW:0]               cnt_q, len_q, len_in;
  logic                      req_valid_q, rsp_ready_q, out_valid_q;
  logic [REG_ADDR_WIDTH-1:0] req_data_q, entry;
  logic [31:0]               out_data_q;
  logic [CW-1:0]             out_dest_q;
  logic                      busy_q, frame_done_q, overrun_q;

  fcore_rdsched_table #(
    .CHANNELS_MAX   (CHANNELS_MAX),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_table (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we_i    (cfg_we_i),
    .waddr_i (cfg_addr_i),
    .wdata_i (cfg_data_i),
    .raddr_i (cnt_q[CW-1:0]),
    .rdata_o (entry)
  );

  // Frame length saturates at the table size.
  assign len_in = (n_channels_i > (CW+1)'(CHANNELS_MAX)) ? (CW+1)'(CHANNELS_MAX) : n_channels_i;

`ifdef FCORE_RDSCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_err_q;
`endif

  // Frame sequencer; all handshake and status outputs are registered here.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      req_valid_q  <= 1'b0;
      req_data_q   <= '0;
      rsp_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_dest_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef FCORE_RDSCHED_TIMEOUT_EN
      tmo_q        <= '0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (trigger_i && state_q != IDLE) overrun_q <= 1'b1;
      unique case (state_q)
        // An empty frame still passes through SCAN, which finds counter == 0 == L at once.
        IDLE: begin
          if (trigger_i) begin
            len_q   <= len_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (cnt_q == len_q) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else if (entry == '0) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            req_valid_q <= 1'b1;
            req_data_q  <= entry;
            state_q     <= REQUEST;
          end
        end
        REQUEST: begin
          if (read_request_ready_i) begin
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            state_q     <= WAIT_RESP;
`ifdef FCORE_RDSCHED_TIMEOUT_EN
            tmo_q       <= '0;
`endif
          end
        end
        WAIT_RESP: begin
          if (read_response_valid_i) begin
            rsp_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= 32'(read_response_data_i);
            out_dest_q  <= cnt_q[CW-1:0];
            state_q     <= EMIT;
          end
`ifdef FCORE_RDSCHED_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= TIMEOUT_FILL;
            out_dest_q  <= cnt_q[CW-1:0];
            tmo_err_q   <= 1'b1;
            state_q     <= EMIT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        EMIT: begin
          if (data_out_ready_i) begin
            out_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
            state_q     <= SCAN;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_request_valid_o  = req_valid_q;
  assign read_request_data_o   = req_data_q;
  assign read_response_ready_o = rsp_ready_q;
  assign data_out_valid_o      = out_valid_q;
  assign data_out_data_o       = out_data_q;
  assign data_out_dest_o       = out_dest_q;
  assign busy_o                = busy_q;
  assign frame_done_o          = frame_done_q;
  assign overrun_o             = overrun_q;
`ifdef FCORE_RDSCHED_TIMEOUT_EN
  assign timeout_err_o         = tmo_err_q;
`else
  assign timeout_err_o         = 1'b0;
`endif

endmodule
